// File: rtl/fetch_queue.sv
// Two-wide instruction fetch queue between IF and decode, a circular buffer with compacting enqueue.
// Optional sticky overflow detection is built only when FETCH_QUEUE_CHECK_EN is defined.
module fetch_queue #(
   parameter int DEPTH           = 8,
   parameter int INST_WIDTH      = 32,
   parameter int INST_ADDR_WIDTH = 32,
   parameter int BP_GHR_BITS     = 8,
   parameter int IF_BATCH_SIZE   = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       redirect_valid,
   input  logic [INST_WIDTH-1:0]      in_inst_addr_0,
   input  logic [INST_WIDTH-1:0]      in_inst_addr_1,
   input  logic [INST_WIDTH-1:0]      in_inst_0,
   input  logic [INST_WIDTH-1:0]      in_inst_1,
   input  logic [IF_BATCH_SIZE-1:0]   in_inst_valid,
   input  logic                       in_pred_taken_0,
   input  logic                       in_pred_taken_1,
   input  logic [INST_ADDR_WIDTH-1:0] in_pred_target_0,
   input  logic [INST_ADDR_WIDTH-1:0] in_pred_target_1,
   input  logic [BP_GHR_BITS-1:0]     in_pred_hist_0,
   input  logic [BP_GHR_BITS-1:0]     in_pred_hist_1,
   output logic                       stall,
   output logic [INST_WIDTH-1:0]      out_inst_addr_0,
   output logic [INST_WIDTH-1:0]      out_inst_addr_1,
   output logic [INST_WIDTH-1:0]      out_inst_0,
   output logic [INST_WIDTH-1:0]      out_inst_1,
   output logic                       out_pred_taken_0,
   output logic                       out_pred_taken_1,
   output logic [INST_ADDR_WIDTH-1:0] out_pred_target_0,
   output logic [INST_ADDR_WIDTH-1:0] out_pred_target_1,
   output logic [BP_GHR_BITS-1:0]     out_pred_hist_0,
   output logic [BP_GHR_BITS-1:0]     out_pred_hist_1,
   output logic [1:0]                 out_inst_valid,
   input  logic                       dec_ready,
   output logic                       overflow_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [INST_WIDTH-1:0]      addr;
      logic [INST_WIDTH-1:0]      inst;
      logic                       taken;
      logic [INST_ADDR_WIDTH-1:0] target;
      logic [BP_GHR_BITS-1:0]     hist;
   } entry_t;

   entry_t        mem [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic [CW-1:0] push_n;
   logic [CW-1:0] pop_n;
   logic [CW-1:0] free_n;
   logic [CW-1:0] wr_n;
   logic          clear;
   entry_t        ent_0;
   entry_t        ent_1;
   entry_t        wr_first;
   entry_t        rd_0;
   entry_t        rd_1;

   assign clear = flush | redirect_valid;

   always_comb begin
      ent_0    = {in_inst_addr_0, in_inst_0, in_pred_taken_0, in_pred_target_0, in_pred_hist_0};
      ent_1    = {in_inst_addr_1, in_inst_1, in_pred_taken_1, in_pred_target_1, in_pred_hist_1};
      push_n   = CW'(in_inst_valid[0]) + CW'(in_inst_valid[1]);
      pop_n    = '0;
      if (dec_ready) begin
         pop_n = (count >= CW'(2)) ? CW'(2) : count;
      end
      // free space counts the slots decode releases this same cycle
      free_n   = CW'(DEPTH) - count + pop_n;
      wr_n     = (push_n > free_n) ? free_n : push_n;
      wr_first = in_inst_valid[0] ? ent_0 : ent_1;
   end

   always_ff @(posedge clk) begin
      if (!rst && !clear) begin
         if (wr_n != '0) begin
            mem[tail] <= wr_first;
         end
         if (wr_n == CW'(2)) begin
            mem[tail + PW'(1)] <= ent_1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + pop_n[PW-1:0];
         tail  <= tail + wr_n[PW-1:0];
         count <= count + wr_n - pop_n;
      end
   end

   assign rd_0 = mem[head];
   assign rd_1 = mem[head + PW'(1)];

   assign out_inst_addr_0   = rd_0.addr;
   assign out_inst_addr_1   = rd_1.addr;
   assign out_inst_0        = rd_0.inst;
   assign out_inst_1        = rd_1.inst;
   assign out_pred_taken_0  = rd_0.taken;
   assign out_pred_taken_1  = rd_1.taken;
   assign out_pred_target_0 = rd_0.target;
   assign out_pred_target_1 = rd_1.target;
   assign out_pred_hist_0   = rd_0.hist;
   assign out_pred_hist_1   = rd_1.hist;

   assign out_inst_valid = {count >= CW'(2), count != '0};
   assign stall          = (CW'(DEPTH) - count) < CW'(4);

`ifdef FETCH_QUEUE_CHECK_EN
   logic ovf_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (!clear && (push_n > free_n)) begin
         ovf_q <= 1'b1;
      end
   end

   assign overflow_err = ovf_q;
`else
   assign overflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic against a queue-based model.
module tb_fetch_queue;

   localparam int DEPTH = 8;
   localparam int IW    = 32;
   localparam int AW    = 32;
   localparam int GH    = 8;
`ifdef FETCH_QUEUE_CHECK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   typedef struct packed {
      logic [IW-1:0] addr;
      logic [IW-1:0] inst;
      logic          taken;
      logic [AW-1:0] target;
      logic [GH-1:0] hist;
   } ent_t;

   logic          clk = 1'b0;
   logic          rst, flush, redirect_valid, dec_ready;
   logic [IW-1:0] in_inst_addr_0, in_inst_addr_1, in_inst_0, in_inst_1;
   logic [1:0]    in_inst_valid;
   logic          in_pred_taken_0, in_pred_taken_1;
   logic [AW-1:0] in_pred_target_0, in_pred_target_1;
   logic [GH-1:0] in_pred_hist_0, in_pred_hist_1;
   logic          stall, overflow_err;
   logic [IW-1:0] out_inst_addr_0, out_inst_addr_1, out_inst_0, out_inst_1;
   logic          out_pred_taken_0, out_pred_taken_1;
   logic [AW-1:0] out_pred_target_0, out_pred_target_1;
   logic [GH-1:0] out_pred_hist_0, out_pred_hist_1;
   logic [1:0]    out_inst_valid;

   always #5 clk = ~clk;

   fetch_queue #(.DEPTH(DEPTH), .INST_WIDTH(IW), .INST_ADDR_WIDTH(AW), .BP_GHR_BITS(GH)) dut (
      .clk(clk), .rst(rst), .flush(flush), .redirect_valid(redirect_valid),
      .in_inst_addr_0(in_inst_addr_0), .in_inst_addr_1(in_inst_addr_1),
      .in_inst_0(in_inst_0), .in_inst_1(in_inst_1), .in_inst_valid(in_inst_valid),
      .in_pred_taken_0(in_pred_taken_0), .in_pred_taken_1(in_pred_taken_1),
      .in_pred_target_0(in_pred_target_0), .in_pred_target_1(in_pred_target_1),
      .in_pred_hist_0(in_pred_hist_0), .in_pred_hist_1(in_pred_hist_1),
      .stall(stall),
      .out_inst_addr_0(out_inst_addr_0), .out_inst_addr_1(out_inst_addr_1),
      .out_inst_0(out_inst_0), .out_inst_1(out_inst_1),
      .out_pred_taken_0(out_pred_taken_0), .out_pred_taken_1(out_pred_taken_1),
      .out_pred_target_0(out_pred_target_0), .out_pred_target_1(out_pred_target_1),
      .out_pred_hist_0(out_pred_hist_0), .out_pred_hist_1(out_pred_hist_1),
      .out_inst_valid(out_inst_valid), .dec_ready(dec_ready), .overflow_err(overflow_err)
   );

   ent_t q[$];
   bit   m_ovf;
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic ent_t in_ent(input int s);
      if (s == 0) return {in_inst_addr_0, in_inst_0, in_pred_taken_0, in_pred_target_0, in_pred_hist_0};
      return {in_inst_addr_1, in_inst_1, in_pred_taken_1, in_pred_target_1, in_pred_hist_1};
   endfunction

   task automatic model_update();
      int pop;
      int pushn;
      if (rst) begin
         q.delete();
         m_ovf = 1'b0;
      end else if (flush || redirect_valid) begin
         q.delete();
      end else begin
         pop   = dec_ready ? ((q.size() >= 2) ? 2 : q.size()) : 0;
         pushn = int'(in_inst_valid[0]) + int'(in_inst_valid[1]);
         if (pushn > DEPTH - q.size() + pop) m_ovf = 1'b1;
         repeat (pop) void'(q.pop_front());
         for (int s = 0; s < 2; s++) begin
            if (in_inst_valid[s] && q.size() < DEPTH) q.push_back(in_ent(s));
         end
      end
   endtask

   task automatic check_all();
      logic [1:0] ev;
      ent_t       o0, o1;
      ev = {q.size() >= 2, q.size() >= 1};
      o0 = {out_inst_addr_0, out_inst_0, out_pred_taken_0, out_pred_target_0, out_pred_hist_0};
      o1 = {out_inst_addr_1, out_inst_1, out_pred_taken_1, out_pred_target_1, out_pred_hist_1};
      chk("valid", out_inst_valid, ev);
      chk("stall", stall, (DEPTH - q.size()) < 4);
      chk("ovf", overflow_err, CHK_EN & m_ovf);
      if (q.size() >= 1) chk("slot0", o0, q[0]);
      if (q.size() >= 2) chk("slot1", o1, q[1]);
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      check_all();
   endtask

   task automatic set_in(input logic [1:0] m, input logic [31:0] a0, input logic [31:0] a1, input logic dr);
      rst              = 1'b0;
      flush            = 1'b0;
      redirect_valid   = 1'b0;
      in_inst_valid    = m;
      in_inst_addr_0   = a0;
      in_inst_addr_1   = a1;
      dec_ready        = dr;
      in_inst_0        = $urandom;
      in_inst_1        = $urandom;
      in_pred_taken_0  = 1'($urandom);
      in_pred_taken_1  = 1'($urandom);
      in_pred_target_0 = $urandom;
      in_pred_target_1 = $urandom;
      in_pred_hist_0   = 8'($urandom);
      in_pred_hist_1   = 8'($urandom);
   endtask

   task automatic do_reset();
      set_in(2'b00, 0, 0, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   int   got_n, gaps;
   bit   started;
   logic [31:0] rx[$];

   initial begin
      m_ovf = 1'b0;
      do_reset();
      chk("rst_valid", out_inst_valid, 2'b00);
      chk("rst_stall", stall, 1'b0);
      chk("rst_ovf", overflow_err, 1'b0);

      set_in(2'b11, 32'h00, 32'h04, 1'b0);
      step();
      chk("tp1_valid", out_inst_valid, 2'b11);
      chk("tp1_addr0", out_inst_addr_0, 32'h00);
      chk("tp1_addr1", out_inst_addr_1, 32'h04);

      do_reset();
      set_in(2'b01, 32'h10, 32'hdead_0001, 1'b0);
      in_pred_taken_0  = 1'b1;
      in_pred_target_0 = 32'h40;
      step();
      set_in(2'b10, 32'hdead_0002, 32'h44, 1'b0);
      step();
      chk("tp2_addr0", out_inst_addr_0, 32'h10);
      chk("tp2_taken0", out_pred_taken_0, 1'b1);
      chk("tp2_target0", out_pred_target_0, 32'h40);
      chk("tp2_addr1", out_inst_addr_1, 32'h44);
      chk("tp2_valid", out_inst_valid, 2'b11);

      do_reset();
      for (int i = 0; i < 4; i++) begin
         set_in(2'b11, 32'(i * 8), 32'(i * 8 + 4), 1'b0);
         step();
         if (i == 1) chk("stall_c4", stall, 1'b0);
         if (i == 2) chk("stall_c6", stall, 1'b1);
      end
      chk("full_ovf", overflow_err, 1'b0);
      set_in(2'b00, 0, 0, 1'b1);
      step();
      chk("drain_c6", stall, 1'b1);
      step();
      chk("drain_c4", stall, 1'b0);

      do_reset();
      set_in(2'b11, 32'h0, 32'h4, 1'b0); step();
      set_in(2'b11, 32'h8, 32'hc, 1'b0); step();
      set_in(2'b01, 32'h10, 32'h0, 1'b0); step();
      set_in(2'b11, 32'h20, 32'h24, 1'b1);
      flush = 1'b1;
      step();
      chk("flush_valid", out_inst_valid, 2'b00);
      chk("flush_stall", stall, 1'b0);
      set_in(2'b11, 32'h30, 32'h34, 1'b0);
      step();
      chk("post_flush_valid", out_inst_valid, 2'b11);
      chk("post_flush_addr0", out_inst_addr_0, 32'h30);

      do_reset();
      for (int i = 0; i < 3; i++) begin
         set_in(2'b11, 32'(i * 8), 32'(i * 8 + 4), 1'b0);
         step();
      end
      set_in(2'b01, 32'h18, 32'h0, 1'b0); step();
      set_in(2'b11, 32'h50, 32'h54, 1'b0); step();
      chk("ovf_set", overflow_err, CHK_EN);
      set_in(2'b00, 0, 0, 1'b0);
      redirect_valid = 1'b1;
      step();
      chk("ovf_sticky", overflow_err, CHK_EN);

      do_reset();
      got_n = 0; gaps = 0; started = 1'b0;
      rx.delete();
      for (int c = 0; c < 15; c++) begin
         if (c < 10) set_in(2'b11, 32'(c * 8), 32'(c * 8 + 4), 1'b1);
         else        set_in(2'b00, 0, 0, 1'b1);
         if (out_inst_valid[0]) begin
            started = 1'b1;
            rx.push_back(out_inst_addr_0);
         end
         if (out_inst_valid[1]) rx.push_back(out_inst_addr_1);
         if (started && rx.size() < 20 && out_inst_valid != 2'b11) gaps++;
         step();
      end
      got_n = rx.size();
      chk("tput_count", got_n, 20);
      chk("tput_gaps", gaps, 0);
      for (int i = 0; i < 20 && i < rx.size(); i++) chk("tput_order", rx[i], 32'(i * 4));

      do_reset();
      for (int c = 0; c < 600; c++) begin
         set_in(2'($urandom), $urandom, $urandom, ($urandom_range(0, 9) < 6));
         flush          = ($urandom_range(0, 29) == 0);
         redirect_valid = ($urandom_range(0, 29) == 0);
         rst            = ($urandom_range(0, 149) == 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
